pipelined_subtractor: RTL and testbench
=======================================

PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, operand width in bits.
REQ-002 SHALL have parameter BITS_PER_STAGE, default 6, bits resolved per pipeline stage; N_STAGES = DATA_WIDTH/BITS_PER_STAGE (default 4); DATA_WIDTH not a multiple of BITS_PER_STAGE is an elaboration error.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port resetn, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port a, input, DATA_WIDTH, minuend (unsigned).
REQ-006 SHALL have port b, input, DATA_WIDTH, subtrahend (unsigned).
REQ-007 SHALL have port in_valid, input, 1, a/b valid this cycle.
REQ-008 SHALL have port in_ready, output, 1, block accepts a/b this cycle.
REQ-009 SHALL have port result, output, DATA_WIDTH+1, {borrow, difference}.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.

Function
REQ-012 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready, at the rising edge.
REQ-013 SHALL compute result = {1'b0,a} - {1'b0,b} mod 2^(DATA_WIDTH+1); result[DATA_WIDTH] = 1 exactly when a < b.
REQ-014 SHALL implement N_STAGES register stages; stage k resolves bits [k*BITS_PER_STAGE +: BITS_PER_STAGE] with a per-bit ripple borrow chain (d = a^b^bin, bout = (~a&b) | (~(a^b)&bin)), borrow-in from stage k-1's registered borrow, borrow-in of stage 0 = 0.
REQ-015 SHALL carry unresolved operand slices and resolved difference slices forward in stage registers alongside a per-stage valid bit.
REQ-016 SHALL have latency N_STAGES cycles (default 4) from input transfer to out_valid when out_ready stays high.
REQ-017 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-018 SHALL advance stage k when stage k+1 is empty or advancing; final stage advances when empty or out_ready=1.
REQ-019 SHALL drive in_ready = stage-0 empty or stage 0 advancing (combinational from out_ready permitted).
REQ-020 SHALL hold result and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL lose no transfer and duplicate no transfer under any in_valid/out_ready pattern, including simultaneous accept and release in the same cycle with the pipeline full.
REQ-022 SHALL preserve transfer order.
REQ-023 SHALL ignore a and b when in_valid=0 or in_ready=0.

Reset
REQ-024 SHALL, on resetn=0 at a rising edge, clear all stage valid bits; out_valid=0, result=0, in_ready=0 during reset.
REQ-025 SHALL discard all in-flight operations on reset asserted mid-operation; none appear on result afterwards.
REQ-026 SHALL assert in_ready=1 the first cycle after resetn returns high.

Configuration
REQ-027 SHALL, when macro PIPELINED_SUBTRACTOR_OVF_EN is defined, add output port ovf (1 bit) aligned with result, = 1 when a-b overflows as signed two's complement (a[MSB]!=b[MSB] and diff[MSB]!=a[MSB]), 0 at reset.
REQ-028 SHALL, when PIPELINED_SUBTRACTOR_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: a=100, b=1, out_ready=1 -> result=0x0000063, out_valid exactly 4 cycles after transfer.
REQ-030 SHALL cover: a=0, b=1 -> result=0x1FFFFFF (borrow=1, diff=0xFFFFFF); a=0xFFFFFF, b=0xFFFFFF -> result=0x0000000.
REQ-031 SHALL cover: 20 back-to-back random pairs, out_ready=1 -> 20 correct results on consecutive cycles, in order, in_ready never low.
REQ-032 SHALL cover: out_ready=0 for 10 cycles while feeding -> in_ready drops after 4 accepts, result held stable; release -> all 4 drain in order, no loss.
REQ-033 SHALL cover: resetn=0 for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, no stale result ever emitted, next op correct.
REQ-034 SHALL cover (OVF_EN defined): a=0x800000, b=0x000001 -> result=0x07FFFFF, ovf=1; a=5, b=3 -> ovf=0.

Source files
------------

// File: rtl/pipelined_subtractor.sv
// Valid/ready pipelined unsigned subtractor producing {borrow, a-b} one slice per stage.
// Define PIPELINED_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module pipelined_subtractor #(
    parameter int DATA_WIDTH     = 24,
    parameter int BITS_PER_STAGE = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH:0]   result,
    output logic                  out_valid,
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
    output logic                  ovf,
`endif
    input  logic                  out_ready
);

    localparam int N_STAGES = DATA_WIDTH / BITS_PER_STAGE;

    if ((DATA_WIDTH % BITS_PER_STAGE) != 0) begin : g_width_chk
        $error("DATA_WIDTH must be a multiple of BITS_PER_STAGE");
    end

    function automatic logic [BITS_PER_STAGE:0] sub_slice(
        input logic [BITS_PER_STAGE-1:0] x,
        input logic [BITS_PER_STAGE-1:0] y,
        input logic                      bin
    );
        logic [BITS_PER_STAGE-1:0] d;
        logic                      br;
        d  = '0;
        br = bin;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    logic [N_STAGES-1:0]       r_vld;
    logic [N_STAGES-1:0]       r_bor;
    logic [DATA_WIDTH-1:0]     r_a [N_STAGES];
    logic [DATA_WIDTH-1:0]     r_b [N_STAGES];
    logic [DATA_WIDTH-1:0]     r_d [N_STAGES];

    logic [N_STAGES-1:0]       w_ld;
    logic [N_STAGES-1:0]       w_vin;
    logic [N_STAGES-1:0]       w_bi;
    logic [DATA_WIDTH-1:0]     w_ain  [N_STAGES];
    logic [DATA_WIDTH-1:0]     w_bin  [N_STAGES];
    logic [DATA_WIDTH-1:0]     w_din  [N_STAGES];
    logic [DATA_WIDTH-1:0]     w_dnew [N_STAGES];
    logic [BITS_PER_STAGE:0]   w_s    [N_STAGES];

    // A stage can take new contents when it is empty or everything downstream moves.
    always_comb begin
        logic w_up;
        w_ld  = '0;
        w_vin = '0;
        w_up  = out_ready;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            w_up    = ~r_vld[k] | w_up;
            w_ld[k] = w_up;
        end
        w_vin[0] = in_valid;
        for (int k = 1; k < N_STAGES; k++) begin
            w_vin[k] = r_vld[k-1];
        end
    end

    // Stage inputs: ports feed stage 0, each later stage reads its predecessor.
    always_comb begin
        w_ain[0] = a;
        w_bin[0] = b;
        w_din[0] = '0;
        w_bi     = '0;
        for (int k = 1; k < N_STAGES; k++) begin
            w_ain[k] = r_a[k-1];
            w_bin[k] = r_b[k-1];
            w_din[k] = r_d[k-1];
            w_bi[k]  = r_bor[k-1];
        end
    end

    // Operands are pre-shifted so each stage always works on the low slice; the
    // new difference slice enters at the top and settles into place after N_STAGES.
    always_comb begin
        for (int k = 0; k < N_STAGES; k++) begin
            w_s[k]    = sub_slice(w_ain[k][BITS_PER_STAGE-1:0],
                                  w_bin[k][BITS_PER_STAGE-1:0], w_bi[k]);
            w_dnew[k] = (w_din[k] >> BITS_PER_STAGE)
                      | (DATA_WIDTH'(w_s[k][BITS_PER_STAGE-1:0]) << (DATA_WIDTH - BITS_PER_STAGE));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (w_ld[k]) begin
                    r_vld[k] <= w_vin[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_STAGES; k++) begin
            if (w_ld[k]) begin
                r_a[k]   <= w_ain[k] >> BITS_PER_STAGE;
                r_b[k]   <= w_bin[k] >> BITS_PER_STAGE;
                r_d[k]   <= w_dnew[k];
                r_bor[k] <= w_s[k][BITS_PER_STAGE];
            end
        end
    end

    assign in_ready  = resetn & w_ld[0];
    assign out_valid = resetn & r_vld[N_STAGES-1];
    assign result    = out_valid ? {r_bor[N_STAGES-1], r_d[N_STAGES-1]} : '0;

`ifdef PIPELINED_SUBTRACTOR_OVF_EN
    // Operand MSBs sit in the top bit of the last stage's slice.
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = (w_ain[N_STAGES-1][BITS_PER_STAGE-1] ^ w_bin[N_STAGES-1][BITS_PER_STAGE-1])
                 & (w_s[N_STAGES-1][BITS_PER_STAGE-1] ^ w_ain[N_STAGES-1][BITS_PER_STAGE-1]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (w_ld[N_STAGES-1]) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = out_valid & r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor: a negedge monitor scores every output
// transfer against a queue of model results; scenario tasks add their own checks.
module tb_pipelined_subtractor;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          in_valid;
    logic          in_ready;
    logic [DW:0]   result;
    logic          out_valid;
    logic          out_ready;
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
    logic          ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW+1:0] exp_q [$];

    always #5 clk = ~clk;

    pipelined_subtractor #(
        .DATA_WIDTH     (DW),
        .BITS_PER_STAGE (6)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready)
    );

    function automatic logic [DW+1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] r;
        logic        v;
        r = {1'b0, x} - {1'b0, y};
        v = (x[DW-1] != y[DW-1]) && (r[DW-1] != x[DW-1]);
        return {v, r};
    endfunction

    always @(negedge clk) begin : monitor
        logic [DW+1:0] e;
        if (!resetn) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stale_output: result=%h but nothing was expected", result);
                end else begin
                    e = exp_q.pop_front();
                    if (result !== e[DW:0]) begin
                        bad++;
                        $display("FAIL sb_result: got %h expected %h", result, e[DW:0]);
                    end
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
                    total++;
                    if (ovf !== e[DW+1]) begin
                        bad++;
                        $display("FAIL sb_ovf: got %b expected %b", ovf, e[DW+1]);
                    end
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        logic [31:0] r;
        r = $urandom;
        a = r[DW-1:0];
        r = $urandom;
        b = r[DW-1:0];
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        total++;
        if (result !== '0) begin bad++; $display("FAIL rst_result: got %h expected 0", result); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_out_valid: got %b expected 0", out_valid); end
        next_cycle();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        a = 24'd100;
        b = 24'd1;
        in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (i == 4)) begin
                bad++;
                $display("FAIL lat_out_valid cycle %0d: got %b expected %b", i, out_valid, (i == 4));
            end
            if (i == 4) begin
                total++;
                if (result !== 25'h0000063) begin bad++; $display("FAIL lat_result: got %h expected 0000063", result); end
            end
        end
        next_cycle();
    endtask

    task automatic test_edges();
        logic [DW:0] want [2];
        int          idx;
        want[0] = 25'h1FFFFFF;
        want[1] = 25'h0000000;
        idx = 0;
        a = 24'h000000; b = 24'h000001; in_valid = 1'b1;
        @(negedge clk);
        next_cycle();
        a = 24'hFFFFFF; b = 24'hFFFFFF;
        @(negedge clk);
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && idx < 2) begin
                total++;
                if (result !== want[idx]) begin
                    bad++;
                    $display("FAIL edge_result %0d: got %h expected %h", idx, result, want[idx]);
                end
                idx++;
            end
        end
        total++;
        if (idx != 2) begin bad++; $display("FAIL edge_count: got %0d outputs expected 2", idx); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (c < 20) begin
                drive_rand();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 20) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cycle %0d: got %b expected 1", c, in_ready); end
            end
            total++;
            if (out_valid !== (c >= 4 && c < 24)) begin
                bad++;
                $display("FAIL b2b_out_valid cycle %0d: got %b expected %b", c, out_valid, (c >= 4 && c < 24));
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        int          accepts;
        logic        have_hold;
        logic [DW:0] hold;
        accepts   = 0;
        have_hold = 1'b0;
        hold      = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_rand();
            in_valid = 1'b1;
            @(negedge clk);
            total++;
            if (in_ready !== (c < 4)) begin
                bad++;
                $display("FAIL bp_in_ready cycle %0d: got %b expected %b", c, in_ready, (c < 4));
            end
            if (in_ready) accepts++;
            total++;
            if (out_valid !== (c >= 4)) begin
                bad++;
                $display("FAIL bp_out_valid cycle %0d: got %b expected %b", c, out_valid, (c >= 4));
            end
            if (out_valid) begin
                if (!have_hold) begin
                    hold      = result;
                    have_hold = 1'b1;
                end else begin
                    total++;
                    if (result !== hold) begin bad++; $display("FAIL bp_hold cycle %0d: got %h expected %h", c, result, hold); end
                end
            end
            next_cycle();
        end
        total++;
        if (accepts != 4) begin bad++; $display("FAIL bp_accepts: got %0d expected 4", accepts); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_rand();
            in_valid = 1'b1;
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready cycle %0d: got %b expected 1", c, in_ready); end
            next_cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: %0d results outstanding expected 0", exp_q.size()); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        logic got;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_rand();
            in_valid = 1'b1;
            @(negedge clk);
            next_cycle();
        end
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_quiet %0d: got %b expected 0", i, out_valid); end
        end
        next_cycle();
        a = 24'd1000; b = 24'd7; in_valid = 1'b1;
        @(negedge clk);
        next_cycle();
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                total++;
                if (result !== 25'd993) begin bad++; $display("FAIL mid_rst_next_result: got %h expected %h", result, 25'd993); end
                break;
            end
        end
        total++;
        if (!got) begin bad++; $display("FAIL mid_rst_next_timeout: got no output expected one"); end
        next_cycle();
    endtask

`ifdef PIPELINED_SUBTRACTOR_OVF_EN
    task automatic test_ovf();
        logic [DW:0] want_r [2];
        logic        want_v [2];
        int          idx;
        want_r[0] = 25'h07FFFFF; want_v[0] = 1'b1;
        want_r[1] = 25'h0000002; want_v[1] = 1'b0;
        idx = 0;
        out_ready = 1'b1;
        a = 24'h800000; b = 24'h000001; in_valid = 1'b1;
        @(negedge clk);
        next_cycle();
        a = 24'd5; b = 24'd3;
        @(negedge clk);
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && idx < 2) begin
                total++;
                if (result !== want_r[idx]) begin bad++; $display("FAIL ovf_result %0d: got %h expected %h", idx, result, want_r[idx]); end
                total++;
                if (ovf !== want_v[idx]) begin bad++; $display("FAIL ovf_flag %0d: got %b expected %b", idx, ovf, want_v[idx]); end
                idx++;
            end
        end
        total++;
        if (idx != 2) begin bad++; $display("FAIL ovf_count: got %0d outputs expected 2", idx); end
        next_cycle();
    endtask
`endif

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        test_reset();
        test_latency();
        test_edges();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
        test_ovf();
`endif
        repeat (6) next_cycle();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL final_queue: %0d results outstanding expected 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
